// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide unit controller for the E stage of a 5-stage
//               MIPS pipeline. Owns HI/LO, sequences multi-cycle
//               mult/multu/div/divu with a busy counter, and raises the stall
//               request for a D-stage HI/LO user while the unit is occupied.
// Ports       : clk       - clock
//               reset     - synchronous, active-high reset
//               md_op     - E-stage op (0 none,1 mult,2 multu,3 div,4 divu,
//                           5 mthi,6 mtlo,7 reserved = none)
//               rs_val    - forwarded rs operand
//               rt_val    - forwarded rt operand
//               d_md_use  - D-stage instruction uses the MDU / HI / LO
//               busy      - operation in progress
//               md_stall  - stall request to the hazard unit
//               hi, lo    - HI / LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_pend_wr;   // cleared for divide-by-zero: HI/LO untouched

  // --------------------------------------------------------------------------
  // Result datapath (evaluated in the accept cycle, latched into pend_*)
  // --------------------------------------------------------------------------
  logic        w_is_md_op;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic signed [31:0] w_dvd_s;
  logic signed [31:0] w_dvs_s;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0] w_dvs_u;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;

  assign w_is_md_op = (md_op == c_op_mult) || (md_op == c_op_multu) ||
                      (md_op == c_op_div)  || (md_op == c_op_divu);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  assign w_div_zero = (rt_val == 32'd0);
  // 0x80000000 / -1 overflows; dividing by 1 instead yields the required
  // lo = 0x80000000, hi = 0 without relying on tool overflow behaviour.
  assign w_div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  assign w_dvd_s  = $signed(rs_val);
  assign w_dvs_s  = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(rt_val);
  assign w_quot_s = w_dvd_s / w_dvs_s;   // truncates toward zero
  assign w_rem_s  = w_dvd_s % w_dvs_s;   // takes sign of dividend

  assign w_dvs_u  = w_div_zero ? 32'd1 : rt_val;
  assign w_quot_u = rs_val / w_dvs_u;
  assign w_rem_u  = rs_val % w_dvs_u;

  // --------------------------------------------------------------------------
  // Sequencer: HI/LO ownership and busy countdown
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (r_busy) begin
      // md_op is deliberately ignored while busy
      if (r_cnt == c_cnt_one) begin
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - c_cnt_one;
      end
    end else begin
      case (md_op)
        c_op_mult: begin
          r_pend_hi <= w_prod_s[63:32];
          r_pend_lo <= w_prod_s[31:0];
          r_pend_wr <= 1'b1;
          r_cnt     <= c_mult_load;
          r_busy    <= 1'b1;
        end
        c_op_multu: begin
          r_pend_hi <= w_prod_u[63:32];
          r_pend_lo <= w_prod_u[31:0];
          r_pend_wr <= 1'b1;
          r_cnt     <= c_mult_load;
          r_busy    <= 1'b1;
        end
        c_op_div: begin
          r_pend_hi <= w_rem_s;
          r_pend_lo <= w_quot_s;
          r_pend_wr <= !w_div_zero;
          r_cnt     <= c_div_load;
          r_busy    <= 1'b1;
        end
        c_op_divu: begin
          r_pend_hi <= w_rem_u;
          r_pend_lo <= w_quot_u;
          r_pend_wr <= !w_div_zero;
          r_cnt     <= c_div_load;
          r_busy    <= 1'b1;
        end
        c_op_mthi: r_hi <= rs_val;
        c_op_mtlo: r_lo <= rs_val;
        default: ;
      endcase
    end
  end

  // Combinational so the stall covers the very cycle an operation enters E.
  assign md_stall = d_md_use & (r_busy | w_is_md_op);
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire
